// File: rtl/reg_file_param.sv
// Parameterized register file: two combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending (reservation)
// scoreboard with a registered population count.
module reg_file_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 3,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1,
  parameter bit INIT_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend_a,
  output logic              pend_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             pend;
  logic [NREG-1:0]             pend_nxt;
  logic [ADDR_W:0]             cnt_nxt;
  logic                        wr_ok;
  logic                        rsv_ok;
  logic                        hit_a;
  logic                        hit_b;

  // Reset image of register i; register 0 stays zero when hardwired.
  function automatic logic [DATA_W-1:0] rst_val(input int i);
    if (ZERO_REG && i == 0) return '0;
    return INIT_INDEX ? DATA_W'(i) : '0;
  endfunction

  // Hardwired register 0 swallows both writes and reservations.
  assign wr_ok  = wr_en  && !(ZERO_REG && wr_addr  == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

  // Same-cycle forwarding hits (raw wr_en; address 0 is masked on the data path).
  assign hit_a = BYPASS && wr_en && (wr_addr == rd_addr_a);
  assign hit_b = BYPASS && wr_en && (wr_addr == rd_addr_b);

  // Register storage: reset image, otherwise edge-triggered writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= rst_val(i);
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Next pending vector: writeback clears, reservation sets, set wins on a tie.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok)  pend_nxt[wr_addr]  = 1'b0;
    if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  // Pending bits and their count update together; reset aborts all reservations.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Read port A: zero register first, then bypass, then stored value.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (hit_a) rd_data_a = wr_data;
    if (ZERO_REG && rd_addr_a == '0) rd_data_a = '0;
    pend_a = pend[rd_addr_a] && !hit_a;
  end

  // Read port B: same structure as port A, fully independent.
  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (hit_b) rd_data_b = wr_data;
    if (ZERO_REG && rd_addr_b == '0) rd_data_b = '0;
    pend_b = pend[rd_addr_b] && !hit_b;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; the register count SHALL be NREG = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0, SHALL, when 1, hardwire register 0 to value 0.
REQ-004 Parameter BYPASS, default 1, SHALL, when 1, enable same-cycle write-to-read forwarding.
REQ-005 Parameter INIT_INDEX, default 1, SHALL, when 1, reset register i to value i; when 0, reset every register to 0.
REQ-006 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 rd_addr_a, rd_addr_b  input  ADDR_W each  read port A and read port B addresses.
REQ-009 rd_data_a, rd_data_b  output  DATA_W each  read port A and read port B data, combinational.
REQ-010 wr_en  input  1  writeback strobe.
REQ-011 wr_addr  input  ADDR_W  writeback address.
REQ-012 wr_data  input  DATA_W  writeback data.
REQ-013 rsv_en  input  1  reserve strobe: marks a register as the destination of an in-flight write.
REQ-014 rsv_addr  input  ADDR_W  register to reserve.
REQ-015 pend_a, pend_b  output  1 each  the register addressed by port A or port B has a write outstanding.
REQ-016 pend_cnt  output  ADDR_W+1  number of registers currently reserved.

Function
REQ-017 Writes SHALL be edge-triggered only; the block SHALL contain no latches.
REQ-018 A write SHALL occur when wr_en=1 at the rising edge: reg[wr_addr] <= wr_data, visible in registered state from the next cycle.
REQ-019 Reads SHALL be combinational with zero-cycle latency: rd_data_x = reg[rd_addr_x].
REQ-020 With BYPASS=1, if wr_en=1 and wr_addr equals rd_addr_x, rd_data_x SHALL equal wr_data in the same cycle.
REQ-021 With BYPASS=0, such a same-cycle read SHALL return the old register value.
REQ-022 With ZERO_REG=1: reads of address 0 SHALL return 0, including under bypass; writes and reservations of address 0 SHALL be ignored; register 0 SHALL never be pending.
REQ-023 The block SHALL hold one pending bit per register: rsv_en sets pending[rsv_addr]; wr_en clears pending[wr_addr].
REQ-024 If rsv_en and wr_en target the same address in one cycle, the set SHALL win and the pending bit SHALL end at 1; the data write still occurs.
REQ-025 rsv_en to an already-pending register SHALL leave the bit at 1 and SHALL NOT change pend_cnt.
REQ-026 wr_en to a non-pending register SHALL write data and SHALL NOT change pend_cnt, which never underflows.
REQ-027 pend_x SHALL equal pending[rd_addr_x], masked to 0 when BYPASS=1, wr_en=1 and wr_addr equals rd_addr_x.
REQ-028 pend_cnt SHALL equal the registered population count of the pending bits, updated on the same edge as the bits, with range 0..NREG.
REQ-029 Both read ports SHALL operate independently and may address the same register.

Reset
REQ-030 On rst=1 at a rising edge, every register SHALL load its INIT_INDEX value (register 0 forced to 0 if ZERO_REG=1), all pending bits SHALL clear, and pend_cnt SHALL become 0.
REQ-031 rst SHALL take priority over wr_en and rsv_en in the same cycle, and SHALL abort any outstanding reservation.
REQ-032 rd_data_x SHALL reflect the reset values in the cycle after reset; with BYPASS=1, bypass SHALL still apply combinationally while rst is high.

Verification
REQ-033 Defaults, reset, then rd_addr_a=5 and rd_addr_b=7 -> rd_data_a=5, rd_data_b=7, pend_a=pend_b=0, pend_cnt=0.
REQ-034 wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, rd_addr_a=3, BYPASS=1 -> rd_data_a=0xDEADBEEF in the same cycle; with BYPASS=0 -> 3 that cycle, 0xDEADBEEF the next.
REQ-035 ZERO_REG=1, write 0x55 to register 0 -> reads of address 0 return 0; rsv_en on address 0 -> pend_cnt stays 0.
REQ-036 Reserve register 2, then register 4, then register 2 again -> pend_cnt 1, 2, 2; write register 2 -> pend_cnt 1, pend_a at address 2 = 0.
REQ-037 Same cycle rsv_en and wr_en to register 6, both starting clear -> pending[6]=1, pend_cnt=1, reg[6]=wr_data.
REQ-038 Reserve all NREG registers, then assert rst together with wr_en -> pend_cnt goes NREG then 0; register values return to the INIT_INDEX pattern and the write is dropped.
